// File: rtl/addr_tr_pkg.sv
// Shared types and helpers for the forward and reverse segment address translators.
package addr_tr_pkg;

   localparam int unsigned ADDR_BITCOUNT   = 64;
   localparam int unsigned NUM_SEGS        = 4;
   localparam int unsigned SEG_OFFSET_BITS = 30;

   typedef logic [1:0]                 seg_idx_t;
   typedef logic [ADDR_BITCOUNT-1:0]   addr_t;
   typedef logic [SEG_OFFSET_BITS-1:0] offset_t;

   // Virtual address layout: zeros above, segment index, then the in-segment offset.
   function automatic addr_t make_virt_addr(seg_idx_t seg, offset_t offset);
      return addr_t'({seg, offset});
   endfunction

endpackage

// File: rtl/addr_rev_tr_unit_seg_match.sv
// Per-segment range check: does addr fall in [base, base + segment size)?
module seg_match
   import addr_tr_pkg::*;
(
   input  logic [ADDR_BITCOUNT-1:0]   base,
   input  logic                       valid,
   input  logic [ADDR_BITCOUNT-1:0]   addr,
   output logic                       hit,
   output logic [SEG_OFFSET_BITS-1:0] offset
);

   addr_t diff;

   assign diff   = addr - base;
   // addr >= base guards against a wrapped difference looking small.
   assign hit    = valid & (addr >= base) & (diff[ADDR_BITCOUNT-1:SEG_OFFSET_BITS] == '0);
   assign offset = diff[SEG_OFFSET_BITS-1:0];

endmodule

// File: rtl/addr_rev_tr_unit.sv
// Reverse segment translator: host address -> {seg, offset} virtual address, two-stage valid/ready pipe.
module addr_rev_tr_unit
   import addr_tr_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cfg_wr_en,
   input  logic [1:0]               cfg_wr_idx,
   input  logic [ADDR_BITCOUNT-1:0] cfg_wr_base,
   input  logic                     cfg_clr,
   output logic [NUM_SEGS-1:0]      seg_valid,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_BITCOUNT-1:0] in_host_addr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ADDR_BITCOUNT-1:0] out_virt_addr,
   output logic                     out_hit,
   output logic [1:0]               out_seg
);

   addr_t               bases [NUM_SEGS];
   logic                s1_valid;
   addr_t               s1_addr;
   logic                s1_adv;
   logic                s2_adv;
   logic [NUM_SEGS-1:0] seg_hit;
   offset_t             seg_off [NUM_SEGS];
   logic                match_hit;
   seg_idx_t            match_seg;
   offset_t             match_off;

   assign s2_adv   = ~out_valid | out_ready;
   assign s1_adv   = s1_valid & s2_adv;
   assign in_ready = ~s1_valid | s1_adv;

   // Clear lands before the write so a same-cycle write survives.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_valid <= '0;
         for (int i = 0; i < int'(NUM_SEGS); i++) bases[i] <= '0;
      end else begin
         if (cfg_clr) seg_valid <= '0;
         if (cfg_wr_en) begin
            bases[cfg_wr_idx]     <= cfg_wr_base;
            seg_valid[cfg_wr_idx] <= 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_SEGS; g++) begin : g_seg
      seg_match u_match (
         .base   (bases[g]),
         .valid  (seg_valid[g]),
         .addr   (s1_addr),
         .hit    (seg_hit[g]),
         .offset (seg_off[g])
      );
   end

   // Scan high to low so the lowest-index overlapping segment wins.
   always_comb begin
      match_hit = 1'b0;
      match_seg = '0;
      match_off = '0;
      for (int i = int'(NUM_SEGS) - 1; i >= 0; i--) begin
         if (seg_hit[i]) begin
            match_hit = 1'b1;
            match_seg = seg_idx_t'(i);
            match_off = seg_off[i];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_addr  <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) s1_addr <= in_host_addr;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid     <= 1'b0;
         out_hit       <= 1'b0;
         out_seg       <= '0;
         out_virt_addr <= '0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_hit       <= match_hit;
            out_seg       <= match_seg;
            out_virt_addr <= match_hit ? make_virt_addr(match_seg, match_off) : '0;
         end
      end
   end

endmodule

// File: doc/addr_rev_tr_unit.md
Name: addr_rev_tr_unit

Overview:
- Reverse of the segment address translator: maps a 64-bit host address back to the accelerator-side "virtual" address, i.e. {32'b0, seg[1:0], offset[29:0]}.
- Four 1 GB segments, each with a programmable host base and a valid bit.
- Two-stage pipeline with valid/ready on input and output, plus a config write port for loading bases.
- Sits on the host-response/snoop path, where host addresses must be reported in virtual terms.

Parameters:
- ADDR_BITCOUNT, 64, width of host and virtual addresses.
- SEG_OFFSET_BITS, 30, log2 of segment size (1 GB); the segment index sits at bits [SEG_OFFSET_BITS+1:SEG_OFFSET_BITS].

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_wr_en  in  1  write one base register this cycle.
- cfg_wr_idx  in  2  segment index to write.
- cfg_wr_base  in  ADDR_BITCOUNT  host base address for that segment.
- cfg_clr  in  1  invalidate all four segments.
- seg_valid  out  4  per-segment valid bits.
- in_valid  in  1  host address offered.
- in_ready  out  1  block accepts host address.
- in_host_addr  in  ADDR_BITCOUNT  host address.
- out_valid  out  1  translation result available.
- out_ready  in  1  consumer accepts result.
- out_virt_addr  out  ADDR_BITCOUNT  translated virtual address; 0 on miss.
- out_hit  out  1  1 = address fell inside a valid segment.
- out_seg  out  2  matching segment index; 0 on miss.

Behaviour:
- Reset (async, immediate):
  - All base registers = 0.
  - seg_valid = 4'b0000.
  - Both pipeline stages empty; out_valid = 0, out_virt_addr = 0, out_hit = 0, out_seg = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
  - Reset mid-operation drops all in-flight requests silently.
- Config:
  - cfg_wr_en loads base[cfg_wr_idx] and sets seg_valid[cfg_wr_idx] on the next edge.
  - cfg_clr clears all seg_valid bits; bases are retained.
  - cfg_clr and cfg_wr_en in the same cycle: the clear applies first, then the write. Only the written segment ends valid.
  - Config writes never stall the datapath.
- Stage 1 (S1):
  - Registers in_host_addr on the in_valid & in_ready handshake.
- S1 to S2 transfer:
  - Computes per segment i: hit_i = seg_valid[i] & (addr >= base[i]) & ((addr - base[i]) < 2^SEG_OFFSET_BITS).
  - The comparison is unsigned on full width. A base near 2^64 must not falsely hit via wrap-around.
  - Uses base and seg_valid values as they stand before any same-cycle config write; a write takes effect for transfers on the next cycle onward.
- Stage 2 (S2):
  - On hit, the lowest-index hitting segment wins when segments overlap. out_hit = 1, out_seg = that index, out_virt_addr = {zeros, seg, (addr - base)[29:0]}.
  - On miss, out_hit = 0, out_seg = 0, out_virt_addr = 0.
- Latency:
  - Two cycles from input handshake to out_valid when unstalled.
  - Full throughput: one result per cycle.
- Flow control:
  - S2 advances when it is empty or out_ready = 1.
  - S1 advances when it holds valid data and S2 advances.
  - in_ready = ~S1_valid | S1_advance, i.e. combinational from out_ready through the two-deep pipeline.
  - No bubbles under continuous traffic; no drop or duplication under any stall pattern.
- Output stability: while out_valid & ~out_ready, all out_* signals hold stable.
- Capacity: the maximum in-flight count is 2. When both stages are full and out_ready = 0, in_ready = 0.

Decomposition:
- Shared package (addr_tr_pkg), reused with the forward translator:
  - NUM_SEGS = 4.
  - SEG_OFFSET_BITS = 30.
  - typedef seg_idx_t (2-bit).
  - typedef addr_t (logic [63:0]).
  - Function make_virt_addr(seg, offset).
- One natural sub-module, seg_match: purely combinational, one per segment. Inputs base, valid, addr; outputs hit and offset. Instantiate 4×.

Test Plan:
- Program base0=0x1_0000_0000, base1=0x2_0000_0000; send 0x2_0000_1234 → two cycles later out_hit=1, out_seg=1, out_virt_addr=0x4000_1234.
- Send 0x1_3FFF_FFFF → hit seg0, virt 0x3FFF_FFFF. Send 0x1_4000_0000 with no other valid segment → out_hit=0, out_virt_addr=0.
- base3=0xFFFF_FFFF_F000_0000; send 0x0000_0000_0000_0100 → miss, with no wrap-around false hit. Send 0xFFFF_FFFF_F000_0010 → seg3, virt 0xC000_0010.
- Overlap: base0=base2=0x8000_0000; send 0x8000_0004 → out_seg=0.
- Stream 8 back-to-back addresses with out_ready toggling 1,0,0,1,… → all 8 results arrive in order, none dropped or duplicated. Outputs stay stable while stalled; in_ready=0 exactly when both stages are full and out_ready=0.
- Config race: cfg_clr asserted in the same cycle as the S1→S2 transfer of 0x1_0000_0010 → that result hits seg0 (old state). The next identical request misses. Assert reset with two requests in flight → out_valid=0 immediately, and nothing emitted after reset deasserts.
